// File: rtl/divider_8bit_seq_if.sv
// divider_8bit_seq_if: start/done handshake and result bus for the sequential divider.
interface divider_8bit_seq_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rem;
  logic             V;
  logic             Z;
  modport master (output start, a, b, input busy, done, out, rem, V, Z);
  modport slave  (input start, a, b, output busy, done, out, rem, V, Z);
endinterface

// File: rtl/divider_8bit_seq.sv
// divider_8bit_seq: restoring shift-subtract unsigned divider, one quotient bit per clock.
module divider_8bit_seq #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst_n,
  divider_8bit_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, q_q, q_d;
  logic [WIDTH-1:0] out_q, out_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             v_q, v_d, z_q, z_d;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] r_nx, q_nx;
  logic             ge;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end
  // The kept remainder is always below b, so WIDTH bits suffice between iterations.
  assign r_sh = {r_q, a_q[cnt_q]};
  assign ge   = r_sh >= {1'b0, b_q};
  assign r_nx = ge ? WIDTH'(r_sh - {1'b0, b_q}) : r_sh[WIDTH-1:0];
  assign q_nx = {q_q[WIDTH-2:0], ge};
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rem_d   = rem_q;
    v_d     = v_q;
    z_d     = z_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d   = bus.a;
        b_d   = bus.b;
        r_d   = '0;
        q_d   = '0;
        cnt_d = CW'(WIDTH - 1);
        if (bus.b == '0) begin
          state_d = DONE;
          out_d   = '1;
          rem_d   = bus.a;
          v_d     = 1'b1;
          z_d     = 1'b0;
        end else state_d = RUN;
      end
      RUN: begin
        r_d   = r_nx;
        q_d   = q_nx;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          out_d   = q_nx;
          rem_d   = r_nx;
          v_d     = 1'b0;
          z_d     = q_nx == '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.busy = state_q == RUN;
  assign bus.done = state_q == DONE;
  assign bus.out  = out_q;
  assign bus.rem  = rem_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
endmodule

// File: tb/tb_divider_8bit_seq.sv
// tb_divider_8bit_seq: directed and swept divisions checked through a result scoreboard.
module tb_divider_8bit_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  divider_8bit_seq_if #(.WIDTH(8)) dif ();
  divider_8bit_seq #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(dif.slave));
  typedef struct {logic [7:0] q; logic [7:0] r; logic v; logic z;} exp_t;
  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (dif.busy && dif.done) begin
        n_tests++;
        n_fail++;
        $display("FAIL overlap: busy=%0b done=%0b expected never both high", dif.busy, dif.done);
      end
      if (dif.done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no pending result");
        end else begin
          e = sb.pop_front();
          chk("quotient", dif.out, e.q);
          chk("remainder", dif.rem, e.r);
          chk("V", dif.V, e.v);
          chk("Z", dif.Z, e.z);
        end
      end
    end
  end
  task automatic run(input logic [7:0] a, input logic [7:0] b, input bit mid);
    exp_t e;
    int cyc;
    int bcnt;
    e.v = b == 0;
    e.q = (b == 0) ? 8'hFF : a / b;
    e.r = (b == 0) ? a : a % b;
    e.z = (b != 0) && (e.q == 0);
    bcnt = 0;
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = a;
    dif.b = b;
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
    dif.a = 8'($urandom);
    dif.b = 8'($urandom);
    cyc = 1;
    while (!dif.done && cyc < 20) begin
      if (dif.busy) bcnt++;
      if (mid && cyc == 3) begin
        dif.start = 1'b1;
        dif.a = 8'd1;
        dif.b = 8'd1;
      end
      if (mid && cyc == 4) dif.start = 1'b0;
      @(negedge clk);
      cyc++;
    end
    chk("latency", cyc, (b == 0) ? 1 : 9);
    chk("busy_cycles", bcnt, (b == 0) ? 0 : 8);
  endtask
  initial begin
    dif.start = 1'b0;
    dif.a = '0;
    dif.b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", dif.busy, 0);
    chk("rst_done", dif.done, 0);
    chk("rst_out", dif.out, 0);
    chk("rst_rem", dif.rem, 0);
    chk("rst_V", dif.V, 0);
    chk("rst_Z", dif.Z, 0);
    rst_n = 1'b1;
    run(8'd200, 8'd7, 1'b0);
    run(8'd5, 8'd9, 1'b0);
    run(8'd13, 8'd0, 1'b0);
    run(8'd255, 8'd1, 1'b0);
    run(8'd255, 8'd255, 1'b0);
    run(8'd200, 8'd7, 1'b1);
    // Abort a run mid-way: outputs must clear immediately and no done may follow.
    @(negedge clk);
    dif.start = 1'b1;
    dif.a = 8'd50;
    dif.b = 8'd3;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", dif.busy, 0);
    chk("abort_done", dif.done, 0);
    chk("abort_out", dif.out, 0);
    chk("abort_rem", dif.rem, 0);
    chk("abort_V", dif.V, 0);
    chk("abort_Z", dif.Z, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    run(8'd100, 8'd10, 1'b0);
    for (int i = 0; i < 2000; i++)
      run(8'($urandom), (i % 50 == 0) ? 8'd0 : 8'($urandom), 1'b0);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
